// File: rtl/spike_fifo_pkg.sv
// spike_fifo_pkg: shared SNN constants and spike packet type for the merge, router and FIFOs
package snn_pkg;
    localparam int SPIKE_W         = 32;
    localparam int FIFO_AW_DEFAULT = 4;
    typedef struct packed {
        logic [15:0] neuron;
        logic [15:0] ts;
    } spike_t;
endpackage

// File: rtl/spike_fifo_if.sv
// spike_fifo_if: FIFO write/read/status bundle; master = producer+consumer side, slave = FIFO
interface spike_fifo_if #(
    parameter int DATA_WIDTH = snn_pkg::SPIKE_W,
    parameter int ADDR_WIDTH = snn_pkg::FIFO_AW_DEFAULT
);
    logic                  wen;
    logic [DATA_WIDTH-1:0] din;
    logic                  full;
    logic                  almost_full;
    logic                  read_en;
    logic [DATA_WIDTH-1:0] dout;
    logic                  empty;
    logic [ADDR_WIDTH:0]   count;
    logic                  overflow;
    logic                  underflow;
    logic                  clear_err;
    modport master (
        output wen, din, read_en, clear_err,
        input  full, almost_full, dout, empty, count, overflow, underflow
    );
    modport slave (
        input  wen, din, read_en, clear_err,
        output full, almost_full, dout, empty, count, overflow, underflow
    );
endinterface

// File: rtl/spike_fifo_ram.sv
// spike_fifo_ram: simple dual-port RAM, sync write, sync read-enabled registered output
// ports: clk, rst (clears read register only), we/waddr/wdata, re/raddr, rdata
module spike_fifo_ram #(
    parameter int DW = 32,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem [2**AW];
    logic [DW-1:0] rdata_q;
    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;
    // read-before-write: a same-address read+write (full FIFO) returns the old word
    always_ff @(posedge clk)
        if (rst) rdata_q <= '0;
        else if (re) rdata_q <= mem[raddr];
    assign rdata = rdata_q;
endmodule

// File: rtl/spike_fifo.sv
// spike_fifo: single-clock spike packet FIFO with registered count, flags and sticky errors
// ports: clk, reset (sync, active-high), bus (spike_fifo_if.slave: write/read/status)
module spike_fifo
    import snn_pkg::*;
#(
    parameter int DATA_WIDTH = SPIKE_W,
    parameter int ADDR_WIDTH = FIFO_AW_DEFAULT,
    parameter int AF_LEVEL   = 12
) (
    input  logic       clk,
    input  logic       reset,
    spike_fifo_if.slave bus
);
    localparam logic [ADDR_WIDTH:0] DEPTH = (ADDR_WIDTH+1)'(2**ADDR_WIDTH);
    localparam logic [ADDR_WIDTH:0] AF    = (ADDR_WIDTH+1)'(AF_LEVEL);
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  overflow_q, overflow_d, underflow_q, underflow_d;
    logic                  wr_acc, rd_acc;
    always_comb begin
        // a read frees the slot in the same edge, so full does not block a paired write
        wr_acc      = bus.wen && (!bus.full || bus.read_en);
        rd_acc      = bus.read_en && !bus.empty;
        wr_ptr_d    = wr_ptr_q + ADDR_WIDTH'(wr_acc);
        rd_ptr_d    = rd_ptr_q + ADDR_WIDTH'(rd_acc);
        count_d     = count_q + (ADDR_WIDTH+1)'(wr_acc) - (ADDR_WIDTH+1)'(rd_acc);
        overflow_d  = (bus.wen && bus.full && !bus.read_en) || (overflow_q && !bus.clear_err);
        underflow_d = (bus.read_en && bus.empty) || (underflow_q && !bus.clear_err);
    end
    always_ff @(posedge clk)
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    spike_fifo_ram #(.DW(DATA_WIDTH), .AW(ADDR_WIDTH)) u_ram (
        .clk   (clk),
        .rst   (reset),
        .we    (wr_acc && !reset),
        .waddr (wr_ptr_q),
        .wdata (bus.din),
        .re    (rd_acc && !reset),
        .raddr (rd_ptr_q),
        .rdata (bus.dout)
    );
    assign bus.count       = count_q;
    assign bus.full        = count_q == DEPTH;
    assign bus.empty       = count_q == '0;
    assign bus.almost_full = count_q >= AF;
    assign bus.overflow    = overflow_q;
    assign bus.underflow   = underflow_q;
endmodule

// File: tb/tb_spike_fifo.sv
// tb_spike_fifo: directed and random stimulus against a queue-based FIFO reference model
module tb_spike_fifo;
    logic clk = 1'b0;
    logic reset;
    int   n_vec = 0;
    int   n_err = 0;
    logic [31:0] q[$];
    logic [31:0] m_dout;
    logic        m_ovf, m_udf;
    always #5 clk = ~clk;
    spike_fifo_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) bus ();
    spike_fifo #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .AF_LEVEL(12)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic check_all();
        chk("count", 64'(bus.count), 64'(q.size()));
        chk("empty", 64'(bus.empty), 64'(q.size() == 0));
        chk("full", 64'(bus.full), 64'(q.size() == 16));
        chk("almost_full", 64'(bus.almost_full), 64'(q.size() >= 12));
        chk("dout", 64'(bus.dout), 64'(m_dout));
        chk("overflow", 64'(bus.overflow), 64'(m_ovf));
        chk("underflow", 64'(bus.underflow), 64'(m_udf));
    endtask
    task automatic step(input logic w, input logic [31:0] d, input logic r,
                        input logic c = 1'b0, input logic rs = 1'b0);
        int n;
        bus.wen = w; bus.din = d; bus.read_en = r; bus.clear_err = c; reset = rs;
        @(posedge clk);
        n = q.size();
        if (rs) begin
            q.delete();
            m_dout = '0; m_ovf = 1'b0; m_udf = 1'b0;
        end else begin
            m_ovf = (w && n == 16 && !r) || (m_ovf && !c);
            m_udf = (r && n == 0) || (m_udf && !c);
            if (r && n > 0) m_dout = q.pop_front();
            if (w && (n < 16 || r)) q.push_back(d);
        end
        #1 check_all();
    endtask
    initial begin
        m_dout = '0; m_ovf = 1'b0; m_udf = 1'b0;
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0);
        step(1, 32'h11, 0); step(1, 32'h22, 0); step(1, 32'h33, 0);
        repeat (3) step(0, 0, 1);
        for (int i = 0; i < 16; i++) step(1, 32'h100 + i, 0);
        step(1, 32'h1FF, 0);
        repeat (16) step(0, 0, 1);
        step(0, 0, 0, 1);
        for (int i = 0; i < 16; i++) step(1, 32'h400 + i, 0);
        step(1, 32'hAA, 1);
        repeat (16) step(0, 0, 1);
        step(0, 0, 0, 1);
        step(1, 32'h5, 1);
        step(0, 0, 1);
        step(0, 0, 0, 1);
        for (int i = 0; i < 40; i++) begin
            step(1, 32'h600 + i, i > 0);
            step(0, 0, 1);
        end
        for (int i = 0; i < 7; i++) step(1, 32'h700 + i, 0);
        step(0, 0, 1);
        step(1, 32'h777, 0, 0, 1);
        step(0, 0, 1);
        step(0, 0, 0, 1);
        for (int i = 0; i < 400; i++) begin
            int wp;
            wp = (i % 100) < 50 ? 80 : 25;
            step($urandom_range(99) < wp, $urandom, $urandom_range(99) < 100 - wp,
                 $urandom_range(15) == 0, $urandom_range(63) == 0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
